// File: rtl/csa9_operand_loader_if.sv
// Handshake bundle for csa9_operand_loader: operand input, flush, sum output.
// out_ovf is present only when CSA9_OVF_EN is defined.
interface csa9_operand_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [3:0]  op_count;
`ifdef CSA9_OVF_EN
  logic        out_ovf;
`endif

  modport slave (
    input  in_valid, in_data, flush, out_ready,
`ifdef CSA9_OVF_EN
    output out_ovf,
`endif
    output in_ready, out_valid, out_sum, op_count
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
`ifdef CSA9_OVF_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, out_sum, op_count
  );
endinterface

// File: rtl/csa9_operand_loader.sv
// Serial loader that buffers nine 16-bit operands, sums them through a 9-input
// carry-save tree and hands the sum downstream. Optional macro: CSA9_OVF_EN.
//
// state | meaning
// LOAD  | accepting operands into slot[op_count]
// WAIT  | slots frozen, adder settling for COMPUTE_CYCLES cycles
// DONE  | sum valid, holding until consumed or flushed

module csa9_adder (
  input  logic [15:0] i_num0,
  input  logic [15:0] i_num1,
  input  logic [15:0] i_num2,
  input  logic [15:0] i_num3,
  input  logic [15:0] i_num4,
  input  logic [15:0] i_num5,
  input  logic [15:0] i_num6,
  input  logic [15:0] i_num7,
  input  logic [15:0] i_num8,
  output logic [15:0] o_sum
);
  // 3:2 compressor; result is {carry<<1, sum}, carries beyond bit 15 dropped.
  function automatic logic [31:0] f_csa(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
    logic [15:0] s;
    logic [15:0] cy;
    s  = a ^ b ^ c;
    cy = {((a[14:0] & b[14:0]) | (a[14:0] & c[14:0]) | (b[14:0] & c[14:0])), 1'b0};
    return {cy, s};
  endfunction

  logic [31:0] w_l1a, w_l1b, w_l1c;
  logic [31:0] w_l2a, w_l2b;
  logic [31:0] w_l3;
  logic [31:0] w_l4;

  assign w_l1a = f_csa(i_num0, i_num1, i_num2);
  assign w_l1b = f_csa(i_num3, i_num4, i_num5);
  assign w_l1c = f_csa(i_num6, i_num7, i_num8);
  assign w_l2a = f_csa(w_l1a[15:0], w_l1a[31:16], w_l1b[15:0]);
  assign w_l2b = f_csa(w_l1b[31:16], w_l1c[15:0], w_l1c[31:16]);
  assign w_l3  = f_csa(w_l2a[15:0], w_l2a[31:16], w_l2b[15:0]);
  assign w_l4  = f_csa(w_l3[15:0], w_l3[31:16], w_l2b[31:16]);
  assign o_sum = w_l4[15:0] + w_l4[31:16];
endmodule

module csa9_operand_loader #(
  parameter int COMPUTE_CYCLES = 1,
  parameter int CLEAR_SLOTS    = 0
) (
  input logic                  clk,
  input logic                  rst,
  csa9_operand_loader_if.slave bus
);
  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_wait_cnt;
  logic [3:0]  r_op_count;
  logic        r_out_valid;
  logic [15:0] r_out_sum;
  logic [15:0] r_slot [0:8];
  logic [15:0] w_sum;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_consume;
`ifdef CSA9_OVF_EN
  logic [19:0] r_acc;
  logic        r_out_ovf;
`endif

  assign w_in_ready = (r_state == ST_LOAD) & ~rst;
  assign w_accept   = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_consume  = r_out_valid & bus.out_ready;

  csa9_adder u_adder (
    .i_num0 (r_slot[0]),
    .i_num1 (r_slot[1]),
    .i_num2 (r_slot[2]),
    .i_num3 (r_slot[3]),
    .i_num4 (r_slot[4]),
    .i_num5 (r_slot[5]),
    .i_num6 (r_slot[6]),
    .i_num7 (r_slot[7]),
    .i_num8 (r_slot[8]),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_wait_cnt  <= 2'd0;
      r_op_count  <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_sum   <= 16'd0;
      for (int i = 0; i < 9; i++) r_slot[i] <= 16'd0;
`ifdef CSA9_OVF_EN
      r_acc       <= 20'd0;
      r_out_ovf   <= 1'b0;
`endif
    end else if (bus.flush) begin
      // Flush wins over any handshake; out_sum deliberately keeps its last value.
      r_state     <= ST_LOAD;
      r_wait_cnt  <= 2'd0;
      r_op_count  <= 4'd0;
      r_out_valid <= 1'b0;
      if (CLEAR_SLOTS != 0)
        for (int i = 0; i < 9; i++) r_slot[i] <= 16'd0;
`ifdef CSA9_OVF_EN
      r_acc       <= 20'd0;
      r_out_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            for (int i = 0; i < 9; i++)
              if (r_op_count == 4'(i)) r_slot[i] <= bus.in_data;
            r_op_count <= r_op_count + 4'd1;
`ifdef CSA9_OVF_EN
            r_acc      <= r_acc + {4'd0, bus.in_data};
`endif
            if (r_op_count == 4'd8) begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= 2'(COMPUTE_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            r_out_sum   <= w_sum;
            r_out_valid <= 1'b1;
`ifdef CSA9_OVF_EN
            r_out_ovf   <= (r_acc[19:16] != 4'd0);
`endif
            r_state     <= ST_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        ST_DONE: begin
          if (w_consume) begin
            r_out_valid <= 1'b0;
            r_op_count  <= 4'd0;
            r_state     <= ST_LOAD;
            if (CLEAR_SLOTS != 0)
              for (int i = 0; i < 9; i++) r_slot[i] <= 16'd0;
`ifdef CSA9_OVF_EN
            r_acc       <= 20'd0;
            r_out_ovf   <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.op_count  = r_op_count;
`ifdef CSA9_OVF_EN
  assign bus.out_ovf   = r_out_ovf;
`endif
endmodule

// File: tb/tb_csa9_operand_loader.sv
// Bench for csa9_operand_loader: directed and random operand sets against a
// queue-based sum model, on a COMPUTE_CYCLES=1 and a COMPUTE_CYCLES=4 instance.
module tb_csa9_operand_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst = 1'b1;
  logic        d_valid = 1'b0;
  logic [15:0] d_data = 16'd0;
  logic        d_flush = 1'b0;
  logic        d_oready = 1'b0;
  logic        sel4 = 1'b0;

  csa9_operand_loader_if if1();
  csa9_operand_loader_if if4();

  assign if1.in_valid  = d_valid & ~sel4;
  assign if4.in_valid  = d_valid & sel4;
  assign if1.in_data   = d_data;
  assign if4.in_data   = d_data;
  assign if1.flush     = d_flush;
  assign if4.flush     = d_flush;
  assign if1.out_ready = d_oready;
  assign if4.out_ready = d_oready;

  csa9_operand_loader #(.COMPUTE_CYCLES(1), .CLEAR_SLOTS(0)) dut1 (
    .clk (clk), .rst (d_rst), .bus (if1.slave));
  csa9_operand_loader #(.COMPUTE_CYCLES(4), .CLEAR_SLOTS(1)) dut4 (
    .clk (clk), .rst (d_rst), .bus (if4.slave));

  logic        w_in_ready, w_out_valid;
  logic [15:0] w_out_sum;
  logic [3:0]  w_op_count;
  assign w_in_ready  = sel4 ? if4.in_ready  : if1.in_ready;
  assign w_out_valid = sel4 ? if4.out_valid : if1.out_valid;
  assign w_out_sum   = sel4 ? if4.out_sum   : if1.out_sum;
  assign w_op_count  = sel4 ? if4.op_count  : if1.op_count;
`ifdef CSA9_OVF_EN
  logic w_ovf;
  assign w_ovf = sel4 ? if4.out_ovf : if1.out_ovf;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int t_hs = 0;
  int unsigned q[$];
  logic [15:0] last_sum = 16'd0;

  function automatic int unsigned model_total();
    int unsigned t = 0;
    foreach (q[i]) t += q[i];
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic send_op(input logic [15:0] v, input int gap);
    d_valid = 1'b0;
    repeat (gap) nxt();
    d_valid = 1'b1;
    d_data  = v;
    @(negedge clk);
    check("in_ready_load", 32'(w_in_ready), 32'd1);
    check("op_count_load", 32'(w_op_count), 32'(q.size()));
    t_hs = cyc;
    @(posedge clk);
    q.push_back(32'(v));
    #1;
    d_valid = 1'b0;
  endtask

  task automatic send_const(input logic [15:0] v, input int maxgap);
    for (int i = 0; i < 9; i++) send_op(v, $urandom_range(0, maxgap));
  endtask

  task automatic send_random(input int maxgap);
    for (int i = 0; i < 9; i++) send_op(16'($urandom_range(0, 65535)), $urandom_range(0, maxgap));
  endtask

  // Entered #1 after the 9th handshake edge. end_flush=1 discards the result instead of consuming it.
  task automatic wait_result(input int hold, input bit end_flush);
    int unsigned total;
    logic [15:0] exp_sum;
    int lat;
    bit found;
    int cc;
    total   = model_total();
    exp_sum = total[15:0];
    cc      = sel4 ? 4 : 1;
    found   = 1'b0;
    lat     = 0;
    d_oready = (hold == 0 && !end_flush);
    @(negedge clk);
    check("op_count_nine", 32'(w_op_count), 32'd9);
    check("in_ready_wait", 32'(w_in_ready), 32'd0);
    for (int k = 0; k < 12 && !found; k++) begin
      if (w_out_valid === 1'b1) begin
        found = 1'b1;
        lat = cyc - t_hs;
      end else begin
        @(negedge clk);
      end
    end
    check("result_seen", 32'(found), 32'd1);
    check("latency", 32'(lat), 32'(cc + 1));
    check("out_sum", 32'(w_out_sum), 32'(exp_sum));
`ifdef CSA9_OVF_EN
    check("out_ovf", 32'(w_ovf), 32'(total >= 32'd65536));
`endif
    for (int k = 0; k < hold; k++) begin
      nxt();
      @(negedge clk);
      check("hold_valid", 32'(w_out_valid), 32'd1);
      check("hold_in_ready", 32'(w_in_ready), 32'd0);
      check("hold_sum", 32'(w_out_sum), 32'(exp_sum));
    end
    if (hold > 0 || end_flush) begin
      nxt();
      d_oready = 1'b1;
      d_flush  = end_flush;
    end
    nxt();
    d_oready = 1'b0;
    d_flush  = 1'b0;
    q.delete();
    last_sum = exp_sum;
    @(negedge clk);
    check("after_valid", 32'(w_out_valid), 32'd0);
    check("after_op_count", 32'(w_op_count), 32'd0);
    check("after_in_ready", 32'(w_in_ready), 32'd1);
    check("after_sum_held", 32'(w_out_sum), 32'(last_sum));
`ifdef CSA9_OVF_EN
    check("after_ovf", 32'(w_ovf), 32'd0);
`endif
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_valid;
    // reset
    d_rst = 1'b1;
    nxt();
    @(negedge clk);
    check("reset_in_ready", 32'(w_in_ready), 32'd0);
    nxt();
    d_rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(w_out_valid), 32'd0);
    check("reset_sum", 32'(w_out_sum), 32'd0);
    check("reset_op_count", 32'(w_op_count), 32'd0);
    check("reset_in_ready_after", 32'(w_in_ready), 32'd1);
    nxt();

    // operands 1..9 back to back, out_ready already high
    for (int i = 1; i <= 9; i++) send_op(16'(i), 0);
    check("sum_1_to_9", model_total(), 32'h2D);
    wait_result(0, 1'b0);

    // all ones wraps to 0xFFF7
    send_const(16'hFFFF, 0);
    wait_result(0, 1'b0);
    check("sum_ffff", 32'(last_sum), 32'hFFF7);

    // gapped 0x0100 operands, result held for 5 cycles
    send_const(16'h0100, 3);
    wait_result(5, 1'b0);
    check("sum_0900", 32'(last_sum), 32'h0900);

    // partial set then flush with an operand presented in the same cycle
    for (int i = 0; i < 4; i++) send_op(16'h7777, 0);
    d_valid = 1'b1;
    d_data  = 16'h7777;
    d_flush = 1'b1;
    nxt();
    d_valid = 1'b0;
    d_flush = 1'b0;
    q.delete();
    @(negedge clk);
    check("flush_op_count", 32'(w_op_count), 32'd0);
    check("flush_in_ready", 32'(w_in_ready), 32'd1);
    check("flush_sum_held", 32'(w_out_sum), 32'(last_sum));
    nxt();
    send_const(16'h1000, 1);
    wait_result(0, 1'b0);
    check("sum_9000", 32'(last_sum), 32'h9000);

    // reset during WAIT: no result may escape
    send_random(1);
    d_rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(w_in_ready), 32'd0);
    nxt();
    d_rst = 1'b0;
    q.delete();
    last_sum = 16'd0;
    seen_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (w_out_valid !== 1'b0) seen_valid = 1'b1;
      nxt();
    end
    check("rst_no_valid", 32'(seen_valid), 32'd0);
    @(negedge clk);
    check("rst_op_count", 32'(w_op_count), 32'd0);
    check("rst_in_ready_after", 32'(w_in_ready), 32'd1);
    check("rst_sum", 32'(w_out_sum), 32'd0);
    nxt();
    send_const(16'h0002, 0);
    wait_result(1, 1'b0);
    check("sum_0012", 32'(last_sum), 32'h0012);

    // flush in DONE with out_ready high discards the result
    send_random(2);
    wait_result(2, 1'b1);

    // random sets, random gaps and hold times
    for (int s = 0; s < 6; s++) begin
      send_random(2);
      wait_result($urandom_range(0, 3), 1'b0);
    end

    // longer settle time instance
    sel4 = 1'b1;
    nxt();
    for (int i = 1; i <= 9; i++) send_op(16'(i), 0);
    wait_result(0, 1'b0);
    check("sum_cc4", 32'(last_sum), 32'h2D);
    for (int s = 0; s < 3; s++) begin
      send_random(2);
      wait_result($urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/csa9_operand_loader.md
Name: csa9_operand_loader

Overview:
- Sequential front end for the 9-operand 16-bit carry-save adder, which it instantiates internally.
- Accepts a serial stream of 16-bit operands over a valid/ready handshake and buffers nine of them in a register file.
- Drives the nine buffered operands into the adder, waits a programmable settle time, then captures the sum.
- Presents the captured sum downstream on a valid/ready handshake.

Parameters:
- COMPUTE_CYCLES, 1, settle cycles between 9th operand accept and sum capture; legal range 1-4.
- CLEAR_SLOTS, 0, if 1, all nine operand slots are zeroed when a result is consumed or a flush occurs.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data holds an operand.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  16  operand.
- flush  input  1  discard partial set / pending result.
- out_valid  output  1  out_sum holds a completed sum.
- out_ready  input  1  downstream accepts out_sum.
- out_sum  output  16  registered sum of nine operands, modulo 2^16.
- op_count  output  4  operands stored in current set, 0-9.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, port rst.
- State machine: LOAD, WAIT, DONE.
- Reset values: state=LOAD, op_count=0, out_valid=0, out_sum=0, wait counter=0, slots=0.
- in_ready = (state==LOAD) & ~rst. It is 0 in the cycle rst is high.
- Accept = in_valid & in_ready & ~flush.
  - On accept, in_data is written to slot[op_count] and op_count increments.
  - The first accepted operand is adder input num0; the ninth is num8.
- LOAD->WAIT: on the accept that makes op_count=9, i.e. the 9th handshake.
  - The wait counter is loaded with COMPUTE_CYCLES-1.
- WAIT:
  - in_ready=0.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, out_sum is registered from the adder output, out_valid is set, and state moves to DONE.
- Latency: 9th handshake in cycle T -> out_valid=1 from cycle T+COMPUTE_CYCLES+1.
  - With default COMPUTE_CYCLES=1, that is T+2.
- DONE:
  - in_ready=0; out_sum and out_valid are held stable.
  - On out_valid & out_ready: out_valid=0, op_count=0 (slots zeroed if CLEAR_SLOTS=1), state=LOAD.
  - in_ready=1 on the following cycle; no operand is accepted in the consume cycle.
- Slots are written only in LOAD and are stable for the whole of WAIT.
- Arithmetic: 16-bit wrap-around; the adder carry-out is discarded.
- flush (priority over every handshake in the same cycle):
  - In any state: state=LOAD, op_count=0, out_valid=0, wait counter=0.
  - out_sum keeps its last value.
  - Slots are zeroed if CLEAR_SLOTS=1.
  - An operand presented in the flush cycle is not stored.
  - A result in DONE is discarded even if out_ready is high in that cycle.
- rst mid-operation (LOAD/WAIT/DONE): all state returns to reset values on the next edge. No partial result is ever emitted.
- in_valid in WAIT/DONE is ignored; the producer must hold data until in_ready.
- out_ready outside DONE has no effect.

Optional Feature:
- Macro CSA9_OVF_EN.
- When defined:
  - Adds output port out_ovf (1 bit) and a 20-bit shadow accumulator.
  - The accumulator clears on reset/flush/consume and adds each accepted operand zero-extended.
  - out_ovf is registered with out_sum and equals 1 when the shadow total is >= 65536. It resets to 0, is held in DONE, and clears on consume/flush.
- When undefined: no out_ovf port, no shadow accumulator; behaviour otherwise identical.

Test Plan:
- Reset, then operands 1..9 back-to-back, out_ready=1 -> out_sum=0x002D, out_valid exactly 2 cycles after 9th handshake (COMPUTE_CYCLES=1), out_ovf=0.
- Nine operands of 0xFFFF -> out_sum=0xFFF7, out_ovf=1 when CSA9_OVF_EN defined.
- Operands 0x0100 x9 with random in_valid gaps, out_ready low 5 cycles after out_valid -> in_ready=0 and out_sum=0x0900 stable throughout; then out_ready=1 -> next cycle in_ready=1, op_count=0.
- Four operands 0x7777, then flush together with in_valid=1, then nine operands 0x1000 -> flushed data excluded, out_sum=0x9000, op_count reaches 9.
- rst asserted for 1 cycle during WAIT -> out_valid never rises, op_count=0, in_ready=0 in reset cycle and 1 after; next set 2 x9 -> out_sum=0x0012.
- COMPUTE_CYCLES=4, operands 0x0001..0x0009 -> out_valid at T+5, out_sum=0x002D.
